// File: rtl/af6cesrtl_gapsch_if.sv
// Request/grant bus between the gap-buffer channels and the shared consumer.
interface af6cesrtl_gapsch_if #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CHW  = 2,
  parameter int unsigned INFO = 32
);
  logic [NCH-1:0]      ireq;
  logic [NCH*INFO-1:0] ireqinfo;
  logic [NCH-1:0]      oget;
  logic                irdy;
  logic                ovld;
  logic [INFO-1:0]     oinfo;
  logic [CHW-1:0]      ochid;

  // Scheduler side
  modport master (
    input  ireq, ireqinfo, irdy,
    output oget, ovld, oinfo, ochid
  );

  // Gap-buffer / consumer side
  modport slave (
    output ireq, ireqinfo, irdy,
    input  oget, ovld, oinfo, ochid
  );
endinterface

// File: rtl/af6cesrtl_gapsch.sv
// Round-robin gap-buffer scheduler with sequential per-channel flush sequencing.
module af6cesrtl_gapsch #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CHW     = 2,
  parameter int unsigned INFO    = 32,
  parameter int unsigned HOLD    = 2,
  parameter int unsigned FLSHCYC = 4,
  parameter int unsigned SETTLE  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ienable,
  input  logic [NCH-1:0]       iflshreq,
  af6cesrtl_gapsch_if.master   bus,
  output logic [NCH-1:0]       oflush,
  output logic                 oflshdone,
  output logic [CHW-1:0]       oflshid,
  output logic                 obusy
);

  localparam int unsigned HW = 3;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } fsm_t;

  fsm_t            state;
  logic [CW-1:0]   cnt;
  logic [NCH-1:0]  pend;
  logic [CHW-1:0]  ptr;
  logic [HW-1:0]   hold [NCH];

  logic [NCH-1:0]  elig_c;
  logic            gnt_vld_c;
  logic [CHW-1:0]  gnt_id_c;
  logic [CHW-1:0]  scan_idx_c;
  logic [INFO-1:0] gnt_info_c;
  logic [CHW-1:0]  flsel_c;
  logic [NCH-1:0]  pend_clr_c;

  // Channel is eligible when requesting, enabled, out of hold and not in any flush phase
  always_comb begin
    elig_c = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      elig_c[k] = bus.ireq[k] & ienable[k] & (hold[k] == '0) & ~pend[k]
                  & ~((state != ST_IDLE) && (oflshid == CHW'(k)));
    end
  end

  // Round-robin pick: scan far-to-near so the channel closest after ptr wins
  always_comb begin
    gnt_vld_c  = 1'b0;
    gnt_id_c   = '0;
    scan_idx_c = '0;
    for (int i = int'(NCH); i >= 1; i--) begin
      scan_idx_c = CHW'((int'(ptr) + i) % int'(NCH));
      if (elig_c[scan_idx_c]) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = scan_idx_c;
      end
    end
    if (!bus.irdy) gnt_vld_c = 1'b0;
  end

  // Info word of the winning channel
  always_comb begin
    gnt_info_c = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (gnt_id_c == CHW'(k)) gnt_info_c = bus.ireqinfo[k*INFO +: INFO];
    end
  end

  // Lowest-index pending flush request, and the pend bit it consumes
  always_comb begin
    flsel_c = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (pend[k]) flsel_c = CHW'(k);
    end
    pend_clr_c = ((state == ST_IDLE) && (|pend)) ? (NCH'(1) << flsel_c) : '0;
  end

  // Grant registers, rr pointer and per-channel hold counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.oget  <= '0;
      bus.ovld  <= 1'b0;
      bus.oinfo <= '0;
      bus.ochid <= '0;
      ptr       <= CHW'(NCH - 1);
      for (int k = 0; k < int'(NCH); k++) hold[k] <= '0;
    end else begin
      bus.oget <= gnt_vld_c ? (NCH'(1) << gnt_id_c) : '0;
      bus.ovld <= gnt_vld_c;
      if (gnt_vld_c) begin
        bus.oinfo <= gnt_info_c;
        bus.ochid <= gnt_id_c;
        ptr       <= gnt_id_c;
      end
      for (int k = 0; k < int'(NCH); k++) begin
        if (gnt_vld_c && (gnt_id_c == CHW'(k))) hold[k] <= HW'(HOLD);
        else if (hold[k] != '0)                 hold[k] <= hold[k] - HW'(1);
      end
    end
  end

  // Flush sequencer: latch requests, assert oflush, wait out the settle window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend      <= '0;
      oflush    <= '0;
      oflshdone <= 1'b0;
      oflshid   <= '0;
      obusy     <= 1'b0;
    end else begin
      oflshdone <= 1'b0;
      pend      <= (pend & ~pend_clr_c) | iflshreq;
      case (state)
        ST_IDLE: begin
          if (|pend) begin
            state   <= ST_ASSERT;
            oflush  <= NCH'(1) << flsel_c;
            oflshid <= flsel_c;
            cnt     <= CW'(FLSHCYC - 1);
            obusy   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (cnt == '0) begin
            state     <= ST_SETTLE;
            oflush    <= '0;
            cnt       <= CW'(SETTLE - 1);
            oflshdone <= (SETTLE == 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            obusy <= 1'b0;
          end else begin
            cnt       <= cnt - CW'(1);
            oflshdone <= (cnt == CW'(1));
          end
        end
        default: begin
          state  <= ST_IDLE;
          oflush <= '0;
          obusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_af6cesrtl_gapsch.sv
// Randomized bench for af6cesrtl_gapsch against a timeline-based reference model.
module tb_af6cesrtl_gapsch;

  localparam int unsigned NCH     = 4;
  localparam int unsigned CHW     = 2;
  localparam int unsigned INFO    = 32;
  localparam int unsigned HOLD    = 2;
  localparam int unsigned FLSHCYC = 4;
  localparam int unsigned SETTLE  = 3;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] ienable;
  logic [NCH-1:0] iflshreq;
  logic [NCH-1:0] oflush;
  logic           oflshdone;
  logic [CHW-1:0] oflshid;
  logic           obusy;

  af6cesrtl_gapsch_if #(.NCH(NCH), .CHW(CHW), .INFO(INFO)) bif ();

  af6cesrtl_gapsch #(
    .NCH(NCH), .CHW(CHW), .INFO(INFO),
    .HOLD(HOLD), .FLSHCYC(FLSHCYC), .SETTLE(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ienable   (ienable),
    .iflshreq  (iflshreq),
    .bus       (bif),
    .oflush    (oflush),
    .oflshdone (oflshdone),
    .oflshid   (oflshid),
    .obusy     (obusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle index, rr pointer, remaining hold cycles, pending
  // flushes, and the current flush as a (channel, start cycle, end cycle) timeline.
  int              cyc;
  int              m_ptr;
  int              m_hold [NCH];
  bit              m_pend [NCH];
  int              fl_ch;
  int              fl_start;
  int              fl_end;
  logic [NCH-1:0]  e_oget;
  logic            e_ovld;
  logic [INFO-1:0] e_oinfo;
  int              e_ochid;
  int              e_flid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    m_ptr    = NCH - 1;
    for (int k = 0; k < NCH; k++) begin
      m_hold[k] = 0;
      m_pend[k] = 1'b0;
    end
    fl_ch    = -1;
    fl_start = -10;
    fl_end   = -1;
    e_oget   = '0;
    e_ovld   = 1'b0;
    e_oinfo  = '0;
    e_ochid  = 0;
    e_flid   = 0;
  endtask

  // Compare every DUT output against the model's view of the current cycle
  task automatic check_outputs();
    logic [NCH-1:0] e_fl;
    logic           e_done;
    logic           e_busy;
    e_fl = '0;
    if (fl_ch >= 0 && cyc >= fl_start + 1 && cyc <= fl_start + int'(FLSHCYC)) e_fl[fl_ch] = 1'b1;
    e_done = (fl_ch >= 0) && (cyc == fl_end);
    e_busy = (fl_ch >= 0) && (cyc > fl_start) && (cyc <= fl_end);
    check_eq("oget",      64'(bif.oget),  64'(e_oget));
    check_eq("ovld",      64'(bif.ovld),  64'(e_ovld));
    check_eq("oinfo",     64'(bif.oinfo), 64'(e_oinfo));
    check_eq("ochid",     64'(bif.ochid), 64'(e_ochid));
    check_eq("oflush",    64'(oflush),    64'(e_fl));
    check_eq("oflshdone", 64'(oflshdone), 64'(e_done));
    check_eq("oflshid",   64'(oflshid),   64'(e_flid));
    check_eq("obusy",     64'(obusy),     64'(e_busy));
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit elig [NCH];
    int win;
    for (int k = 0; k < NCH; k++) begin
      elig[k] = bif.ireq[k] && ienable[k] && (m_hold[k] == 0) && !m_pend[k]
                && !(fl_ch == k && cyc > fl_start && cyc <= fl_end);
    end
    win = -1;
    if (bif.irdy) begin
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (m_ptr + i) % NCH;
        if (win < 0 && elig[c]) win = c;
      end
    end
    for (int k = 0; k < NCH; k++) if (m_hold[k] > 0) m_hold[k]--;
    if (win >= 0) begin
      e_oget       = '0;
      e_oget[win]  = 1'b1;
      e_ovld       = 1'b1;
      e_oinfo      = bif.ireqinfo[win*INFO +: INFO];
      e_ochid      = win;
      m_ptr        = win;
      m_hold[win]  = HOLD;
    end else begin
      e_oget = '0;
      e_ovld = 1'b0;
    end
    if (cyc > fl_end) begin
      for (int k = 0; k < NCH; k++) begin
        if (m_pend[k]) begin
          fl_ch     = k;
          fl_start  = cyc;
          fl_end    = cyc + int'(FLSHCYC) + int'(SETTLE);
          e_flid    = k;
          m_pend[k] = 1'b0;
          break;
        end
      end
    end
    for (int k = 0; k < NCH; k++) if (iflshreq[k]) m_pend[k] = 1'b1;
    cyc++;
  endtask

  task automatic drive(input logic [NCH-1:0] rq, input logic [NCH-1:0] en,
                       input logic rdy, input logic [NCH-1:0] fl);
    bif.ireq = rq;
    ienable  = en;
    bif.irdy = rdy;
    iflshreq = fl;
    for (int k = 0; k < NCH; k++) bif.ireqinfo[k*INFO +: INFO] = INFO'($urandom());
  endtask

  // One cycle: check, apply new inputs, step the model, move to the next sample point
  task automatic cycle(input logic [NCH-1:0] rq, input logic [NCH-1:0] en,
                       input logic rdy, input logic [NCH-1:0] fl);
    check_outputs();
    drive(rq, en, rdy, fl);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive('0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(negedge clk);

    check_eq("reset_oget",      64'(bif.oget),  64'(0));
    check_eq("reset_ovld",      64'(bif.ovld),  64'(0));
    check_eq("reset_oflush",    64'(oflush),    64'(0));
    check_eq("reset_oflshdone", 64'(oflshdone), 64'(0));
    check_eq("reset_obusy",     64'(obusy),     64'(0));
    rst = 1'b1;

    // All channels requesting: strict rotation 0,1,2,3,...
    repeat (20) cycle(4'hF, 4'hF, 1'b1, 4'h0);
    // Single requester throttled by hold
    repeat (15) cycle(4'h4, 4'hF, 1'b1, 4'h0);
    // Consumer back-pressure window
    for (int i = 0; i < 12; i++) cycle(4'h2, 4'hF, !(i >= 2 && i < 7), 4'h0);
    // Two simultaneous flush requests served lowest first
    for (int i = 0; i < 40; i++) cycle(4'hF, 4'hF, 1'b1, (i == 0) ? 4'h5 : 4'h0);
    // Channel 3 disabled, then re-enabled
    repeat (20) cycle(4'hF, 4'h7, 1'b1, 4'h0);
    repeat (10) cycle(4'hF, 4'hF, 1'b1, 4'h0);

    // Reset in the middle of an oflush assertion
    cycle(4'hF, 4'hF, 1'b1, 4'h1);
    repeat (3) cycle(4'hF, 4'hF, 1'b1, 4'h0);
    check_outputs();
    check_eq("pre_rst_obusy", 64'(obusy), 64'(1));
    #2 rst = 1'b0;
    #1;
    check_eq("rst_oflush",    64'(oflush),    64'(0));
    check_eq("rst_obusy",     64'(obusy),     64'(0));
    check_eq("rst_oflshdone", 64'(oflshdone), 64'(0));
    check_eq("rst_oget",      64'(bif.oget),  64'(0));
    check_eq("rst_ovld",      64'(bif.ovld),  64'(0));
    drive('0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) cycle(4'hF, 4'hF, 1'b1, 4'h0);

    // Random traffic with occasional flushes and back-pressure
    repeat (400) begin
      logic [NCH-1:0] rq, en, fl;
      logic           rdy;
      rq  = NCH'($urandom());
      en  = ($urandom_range(0, 7) != 0) ? {NCH{1'b1}} : NCH'($urandom());
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 29) == 0) ? NCH'($urandom()) : '0;
      cycle(rq, en, rdy, fl);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
